riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
Load/store unit on the producer side of the writeback path. It accepts one load/store request from the MEM stage and performs the word-aligned data-memory access over a req/gnt/rvalid bus. It returns the load value, sign- or zero-extended and lane-aligned, as data_o with data_re_o. The writeback mux uses data_o as its memory-data input and data_re_o as its select.

Parameters:
ADDR_W, 32, byte-address width of requests and of the memory bus
DATA_W, 32, data width; fixed to 32 (4 byte lanes), any other value is unsupported

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  MEM stage presents a request
req_ready_o  out  1  LSU can accept a request (high only in IDLE)
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  RISC-V funct3: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101
req_addr_i  in  ADDR_W  byte address
req_wdata_i  in  DATA_W  store data, right-justified
mem_req_o  out  1  bus request
mem_gnt_i  in  1  bus grant
mem_addr_o  out  ADDR_W  word address, bits [1:0] forced to 0
mem_we_o  out  1  bus write enable
mem_be_o  out  4  byte enables
mem_wdata_o  out  DATA_W  lane-replicated store data
mem_rvalid_i  in  1  response or write acknowledge
mem_rdata_i  in  DATA_W  read word
rsp_valid_o  out  1  one-cycle pulse: access complete
data_o  out  DATA_W  extended load result, the writeback memory-data input
data_re_o  out  1  1 = completed op was a load, the writeback select
stall_o  out  1  pipeline hold while busy or on an incoming request
err_o  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset: state IDLE. All outputs 0 except req_ready_o=1.
- IDLE: req_ready_o=1. On req_valid_i, latch we, funct3, addr, wdata and go to REQ.
- REQ: mem_req_o=1. mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o come from registers and stay stable until mem_gnt_i. On gnt, drop mem_req_o next cycle and go to WAIT.
- WAIT: on mem_rvalid_i, register the result and go to DONE. mem_rvalid_i is ignored in every other state; rvalid in the same cycle as gnt is illegal.
- DONE: rsp_valid_o=1 for exactly one cycle. data_o and data_re_o are valid in this cycle and hold until the next DONE. Then go to IDLE.
- Minimum latency: accept in cycle 0, gnt in cycle 1, rvalid in cycle 2, rsp_valid_o in cycle 3.
- stall_o = (state != IDLE) | (state==IDLE & req_valid_i).
- Byte enables, with a = addr[1:0]:
  - SB: 4'b0001 << a
  - SH: 4'b0011 << {a[1],1'b0}
  - SW: 4'b1111
  - Loads: 4'b1111
- Store data: SB replicates the byte into all 4 lanes. SH replicates the half into both halves.
- Load extraction:
  - shifted = mem_rdata_i >> (8*a) for byte loads, >> (16*a[1]) for half loads.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Reserved funct3 (011, 110, 111): treated as LW/SW.
- Stores: data_o = 0 and data_re_o = 0 on completion.
- Reset mid-operation: returns to IDLE immediately and mem_req_o drops; a later stray rvalid is ignored.

Optional Feature:
- Macro: RISCV_LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned request (halfword with a[0]=1, word with a!=0) issues no bus access. It goes IDLE -> DONE in the next cycle with err_o=1, rsp_valid_o=1, data_o=0, data_re_o=0. err_o is a one-cycle pulse, coincident with rsp_valid_o.
- Undefined: err_o is tied 0. The low address bits are dropped per the enable/shift rules above, so no trap is raised.

Decomposition:
- Shared riscv_define.v holds:
  - state encodings
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - `RegBus and `MemDataBus widths
- One natural sub-module, riscv_lsu_align: purely combinational. It maps funct3 + addr[1:0] + data to mem_be_o and replicated write data, and mem_rdata_i to the extended load value. The FSM stays in riscv_lsu.

Test Plan:
- LW addr 0x100, gnt in the first REQ cycle, rdata 0xDEADBEEF -> mem_addr_o=0x100, be=1111, rsp_valid_o in cycle 3, data_o=0xDEADBEEF, data_re_o=1.
- LB addr 0x103, rdata 0x80FF7F01 -> data_o=0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SH addr 0x202, wdata 0x1234ABCD -> mem_addr_o=0x200, be=1100, mem_wdata_o=0xABCDABCD. Completion gives data_re_o=0.
- gnt delayed 3 cycles, rvalid delayed 2 -> address/be/wdata stable throughout REQ, req_ready_o=0 and stall_o=1 until the DONE cycle, exactly one rsp_valid_o pulse.
- rst_n asserted while in WAIT, then a stray rvalid -> all outputs at reset values, no rsp_valid_o, next LW completes normally.
- Macro defined, LW addr 0x101 -> no mem_req_o, err_o=1 and rsp_valid_o=1 in cycle 1. Macro undefined -> access to 0x100 proceeds with be=1111.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 codes, bus widths.
// Also the misalignment predicate used when RISCV_LSU_MISALIGN_TRAP_EN is set.
package riscv_lsu_pkg;

  localparam int REG_BUS      = 32;
  localparam int MEM_DATA_BUS = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Reserved codes (011/110/111) size as words.
  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    if (f3[1:0] == F3_LB[1:0]) return 1'b0;
    if (f3[1:0] == F3_LH[1:0]) return a[0];
    return a != 2'b00;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: byte enables and replicated store data from
// funct3/addr_lo/wdata; extracted, extended load value from rdata.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]              funct3,
  input  logic [1:0]              addr_lo,
  input  logic [MEM_DATA_BUS-1:0] wdata,
  input  logic [MEM_DATA_BUS-1:0] rdata,
  output logic [3:0]              be,
  output logic [MEM_DATA_BUS-1:0] wdata_rep,
  output logic [MEM_DATA_BUS-1:0] rdata_ext
);

  logic       is_b;
  logic       is_h;
  logic       sgn;
  logic [7:0] lane_b;
  logic [15:0] lane_h;

  assign is_b   = funct3[1:0] == F3_LB[1:0];
  assign is_h   = funct3[1:0] == F3_LH[1:0];
  assign sgn    = ~funct3[2];
  assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    unique case (1'b1)
      is_b: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sgn & lane_b[7]}}, lane_b};
      end
      is_h: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sgn & lane_h[15]}}, lane_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one MEM-stage request -> word-aligned req/gnt/rvalid
// access -> extended load data (data_o/data_re_o) for writeback.
// Ports: req_* (MEM stage), mem_* (data bus), rsp_valid_o/data_o/
// data_re_o/err_o (completion), stall_o (pipeline hold).
// Option: RISCV_LSU_MISALIGN_TRAP_EN traps misaligned accesses via err_o.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W = REG_BUS,
  parameter int DATA_W = MEM_DATA_BUS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              data_re_o,
  output logic              stall_o,
  output logic              err_o
);

  state_t            state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be;
  logic [DATA_W-1:0] wrep;
  logic [DATA_W-1:0] ext;

  riscv_lsu_align u_align (
    .funct3    (f3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata_i),
    .be        (be),
    .wdata_rep (wrep),
    .rdata_ext (ext)
  );

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  logic err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_o <= 1'b0;
      data_o      <= '0;
      data_re_o   <= 1'b0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      rsp_valid_o <= 1'b0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      err_q       <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            f3_q    <= req_funct3_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
            if (misaligned(req_funct3_i, req_addr_i[1:0])) begin
              state       <= S_DONE;
              rsp_valid_o <= 1'b1;
              err_q       <= 1'b1;
              data_o      <= '0;
              data_re_o   <= 1'b0;
            end else begin
              state <= S_REQ;
            end
`else
            state <= S_REQ;
`endif
          end
        end
        S_REQ: begin
          if (mem_gnt_i) state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            state       <= S_DONE;
            rsp_valid_o <= 1'b1;
            data_o      <= we_q ? '0 : ext;
            data_re_o   <= ~we_q;
          end
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end

  // Bus fields are zero outside REQ so idle/reset outputs read as 0.
  assign req_ready_o = state == S_IDLE;
  assign stall_o     = (state != S_IDLE) | req_valid_i;
  assign mem_req_o   = state == S_REQ;
  assign mem_we_o    = mem_req_o & we_q;
  assign mem_addr_o  = mem_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be_o    = !mem_req_o ? 4'b0000 : (we_q ? be : 4'b1111);
  assign mem_wdata_o = mem_we_o ? wrep : '0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed cases plus random traffic
// compared against an arithmetic reference model.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        rsp_valid_o;
  logic [31:0] data_o;
  logic        data_re_o;
  logic        stall_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_lsu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .data_o       (data_o),
    .data_re_o    (data_re_o),
    .stall_o      (stall_o),
    .err_o        (err_o)
  );

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes from funct3.
  function automatic int size_of(input logic [2:0] f3);
    if (f3 % 4 == 0) return 1;
    if (f3 % 4 == 1) return 2;
    return 4;
  endfunction

  function automatic int offset_of(input int n, input logic [1:0] a);
    if (n == 1) return int'(a);
    if (n == 2) return (int'(a) / 2) * 2;
    return 0;
  endfunction

  function automatic logic is_mis(input logic [2:0] f3, input logic [1:0] a);
    int n = size_of(f3);
    return (int'(a) % n) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [2:0] f3,
                                       input logic [1:0] a);
    int n = size_of(f3);
    int v;
    if (!we) return 4'hF;
    v = ((1 << n) - 1) << offset_of(n, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3,
                                        input logic [31:0] w);
    int n = size_of(f3);
    if (n == 1) return (w % 256) * 32'h0101_0101;
    if (n == 2) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] f3,
                                        input logic [1:0] a,
                                        input logic [31:0] r);
    int n = size_of(f3);
    longint m = 64'd1 << (8 * n);
    longint v = (longint'(r) / (64'd1 << (8 * offset_of(n, a)))) % m;
    if (f3 < 4 && n < 4 && v >= m / 2) v = v + (64'd1 << 32) - m;
    return v[31:0];
  endfunction

  task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int gd, input int rdd);
    logic [31:0] ed;
    int cyc;
    ed = we ? 32'h0 : exp_ld(f3, addr[1:0], rd);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = wd;
    #1;
    chk1({tag, ":accept_ready"}, req_ready_o, 1'b1);
    chk1({tag, ":accept_stall"}, stall_o, 1'b1);
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_wdata_i = $urandom; req_addr_i = $urandom;
    cyc = 1;
    for (int i = 0; i <= gd; i++) begin
      chk1({tag, ":req"}, mem_req_o, 1'b1);
      chk32({tag, ":addr"}, mem_addr_o, {addr[31:2], 2'b00});
      chk32({tag, ":be"}, {28'h0, mem_be_o}, {28'h0, exp_be(we, f3, addr[1:0])});
      chk1({tag, ":we"}, mem_we_o, we);
      if (we) chk32({tag, ":wdata"}, mem_wdata_o, exp_wd(f3, wd));
      chk1({tag, ":req_ready"}, req_ready_o, 1'b0);
      chk1({tag, ":req_stall"}, stall_o, 1'b1);
      mem_gnt_i = (i == gd);
      mem_rvalid_i = (i != gd) && ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
      cyc++;
    end
    mem_gnt_i = 1'b0;
    for (int i = 0; i <= rdd; i++) begin
      chk1({tag, ":wait_req"}, mem_req_o, 1'b0);
      chk1({tag, ":wait_rsp"}, rsp_valid_o, 1'b0);
      chk1({tag, ":wait_stall"}, stall_o, 1'b1);
      mem_rvalid_i = (i == rdd);
      mem_rdata_i = (i == rdd) ? rd : $urandom;
      @(posedge clk); #1;
      cyc++;
    end
    mem_rvalid_i = 1'b0;
    mem_rdata_i = $urandom;
    chk1({tag, ":rsp"}, rsp_valid_o, 1'b1);
    chk32({tag, ":latency"}, cyc, gd + rdd + 3);
    chk32({tag, ":data"}, data_o, ed);
    chk1({tag, ":data_re"}, data_re_o, ~we);
    chk1({tag, ":err"}, err_o, 1'b0);
    chk1({tag, ":done_ready"}, req_ready_o, 1'b0);
    chk1({tag, ":done_stall"}, stall_o, 1'b1);
    @(posedge clk); #1;
    chk1({tag, ":pulse_end"}, rsp_valid_o, 1'b0);
    chk1({tag, ":idle_ready"}, req_ready_o, 1'b1);
    chk32({tag, ":data_hold"}, data_o, ed);
  endtask

  task automatic chk_reset_state(input string tag);
    chk1({tag, ":ready"}, req_ready_o, 1'b1);
    chk1({tag, ":mem_req"}, mem_req_o, 1'b0);
    chk32({tag, ":mem_addr"}, mem_addr_o, 32'h0);
    chk1({tag, ":mem_we"}, mem_we_o, 1'b0);
    chk32({tag, ":mem_be"}, {28'h0, mem_be_o}, 32'h0);
    chk32({tag, ":mem_wdata"}, mem_wdata_o, 32'h0);
    chk1({tag, ":rsp"}, rsp_valid_o, 1'b0);
    chk32({tag, ":data"}, data_o, 32'h0);
    chk1({tag, ":data_re"}, data_re_o, 1'b0);
    chk1({tag, ":stall"}, stall_o, 1'b0);
    chk1({tag, ":err"}, err_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic we;
    logic [2:0] f3;
    logic [31:0] a;
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b000;
    req_addr_i = 32'h0; req_wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
    do_op("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_7F01, 0, 0);
    do_op("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_7F01, 0, 0);
    do_op("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_7F01, 0, 0);
    do_op("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_7F01, 1, 0);
    do_op("sh", 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 0, 0);
    do_op("sb", 1'b1, 3'b000, 32'h201, 32'h0000_00A5, 32'h0, 0, 1);
    do_op("slow", 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 3, 2);

    // Reset while waiting for rvalid, then a stray rvalid in IDLE.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
    req_addr_i = 32'h400;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    chk1("rst_mid:in_wait", mem_req_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    chk1("stray:rsp", rsp_valid_o, 1'b0);
    @(posedge clk); #1;
    chk_reset_state("stray");
    do_op("lw_after_rst", 1'b0, 3'b010, 32'h100, 32'h0, 32'h0BAD_F00D, 0, 0);

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
    req_addr_i = 32'h101;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk1("trap:mem_req", mem_req_o, 1'b0);
    chk1("trap:err", err_o, 1'b1);
    chk1("trap:rsp", rsp_valid_o, 1'b1);
    chk32("trap:data", data_o, 32'h0);
    chk1("trap:data_re", data_re_o, 1'b0);
    @(posedge clk); #1;
    chk1("trap:err_pulse", err_o, 1'b0);
    chk1("trap:rsp_pulse", rsp_valid_o, 1'b0);
    chk1("trap:ready", req_ready_o, 1'b1);
`else
    do_op("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h7654_3210, 0, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      we = 1'($urandom_range(0, 1));
      if (we) f3 = 3'($urandom_range(0, 3));
      else begin
        f3 = 3'($urandom_range(0, 6));
        if (f3 == 3'd6) f3 = 3'b011;
      end
      a = 32'($urandom_range(0, 4095));
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      if (is_mis(f3, a[1:0])) a[1:0] = 2'b00;
`endif
      do_op("rand", we, f3, a, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
